display_scheduler: RTL and testbench

- Controller in front of the four-digit LED driver; owns and sequences its 16-bit `signal_to_display` word.
- Buffers 16-bit words from the receiver in a small FIFO and shows each word for a guaranteed minimum dwell time.
- Shares the display between received data and a receiver-error indication; the error indication has priority.
- Shows a blank pattern when idle.

---
 rtl/display_scheduler.sv | 233 +++++++++++++++++++++++
 tb/tb_display_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// -----------------------------------------------------------------------------
// display_scheduler
//
// Sits in front of the four-digit LED driver and owns its 16-bit word.
// Words from the receiver are queued in a small FIFO. Each word is shown for at
// least DWELL_CYCLES clocks before the next queued word replaces it. A
// receiver error takes the display over with ERR_WORD until it is cleared.
// IDLE_WORD (blank) is shown after reset and after an error clear.
//
// Optional build macro: DISPLAY_GAP_EN
//   When defined, a blank gap of GAP_CYCLES clocks (IDLE_WORD) is inserted
//   between two consecutive words. The gap is not inserted when no successor
//   word is waiting; the current word is simply held.
//
// Ports:
//   clk               system clock, all logic on posedge
//   reset             asynchronous active-low reset
//   rx_data           received word
//   rx_valid          one-cycle strobe, rx_data valid this cycle
//   rx_ready          FIFO not full (from the registered count)
//   rx_error          one-cycle receiver error strobe
//   err_clear         one-cycle strobe, clears pending error and overflow
//   signal_to_display registered word to the LED driver
//   fifo_count        words currently buffered
//   overflow          sticky, a push was dropped because the FIFO was full
//   disp_busy         high in SHOW while the dwell count is nonzero, and in GAP
// -----------------------------------------------------------------------------
module display_scheduler #(
  parameter int          DWELL_CYCLES = 1024,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] ERR_WORD     = 16'hEEEE,
  parameter logic [15:0] IDLE_WORD    = 16'hFFFF,
  parameter int          GAP_CYCLES   = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   rx_data,
  input  logic                          rx_valid,
  output logic                          rx_ready,
  input  logic                          rx_error,
  input  logic                          err_clear,
  output logic [15:0]                   signal_to_display,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          disp_busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

`ifdef DISPLAY_GAP_EN
  // One counter serves both the dwell and the gap, so it must hold either load.
  localparam int CNT_W = ($clog2(GAP_CYCLES) > $clog2(DWELL_CYCLES)) ?
                         $clog2(GAP_CYCLES) : $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
`else
  localparam int CNT_W = $clog2(DWELL_CYCLES);
`endif
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

  // Elaboration-time parameter sanity checks.
  generate
    if (DWELL_CYCLES < 2) begin : g_bad_dwell
      $error("display_scheduler: DWELL_CYCLES must be >= 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("display_scheduler: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("display_scheduler: GAP_CYCLES must be >= 1");
    end
  endgenerate

`ifdef DISPLAY_GAP_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_ERROR, ST_GAP} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_ERROR} state_t;
`endif

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   dwell_reg, dwell_next;
  logic [FCNT_W-1:0]  fifo_count_reg, fifo_count_next;
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic               err_pending_reg, err_pending_next;
  logic               overflow_reg, overflow_next;
  logic               pop_d_reg;
  logic [15:0]        rd_data_reg;
  logic [15:0]        signal_to_display_reg, signal_to_display_next;
  logic [15:0]        fifo_mem [FIFO_DEPTH];

  logic full, empty, push, pop;

  assign full  = (fifo_count_reg == FCNT_W'(FIFO_DEPTH));
  assign empty = (fifo_count_reg == '0);
  assign push  = rx_valid && !full;

  // ---------------------------------------------------------------------------
  // FIFO storage: no reset, registered read. The read register adds the cycle
  // between the pop decision and the word reaching the display.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= rx_data;
    if (pop)  rd_data_reg <= fifo_mem[rd_ptr_reg];
  end

  always_comb begin
    fifo_count_next = fifo_count_reg;
    case ({push, pop})
      2'b10:   fifo_count_next = fifo_count_reg + FCNT_W'(1);
      2'b01:   fifo_count_next = fifo_count_reg - FCNT_W'(1);
      default: fifo_count_next = fifo_count_reg;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Error / overflow latches. A new event in the same cycle as err_clear wins,
  // so nothing that happens on the clear cycle is lost.
  // ---------------------------------------------------------------------------
  always_comb begin
    err_pending_next = err_pending_reg;
    if (err_clear) err_pending_next = 1'b0;
    if (rx_error)  err_pending_next = 1'b1;
  end

  always_comb begin
    overflow_next = overflow_reg;
    if (err_clear)      overflow_next = 1'b0;
    if (rx_valid && full) overflow_next = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM and dwell/gap counter.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    dwell_next = (dwell_reg != '0) ? (dwell_reg - CNT_W'(1)) : '0;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (err_pending_reg) begin
          state_next = ST_ERROR;
        end else if (!empty) begin
          pop        = 1'b1;
          dwell_next = DWELL_LOAD;
          state_next = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (err_pending_reg) begin
          state_next = ST_ERROR;
        end else if ((dwell_reg == '0) && !empty) begin
`ifdef DISPLAY_GAP_EN
          dwell_next = GAP_LOAD;
          state_next = ST_GAP;
`else
          pop        = 1'b1;
          dwell_next = DWELL_LOAD;
`endif
        end
      end
`ifdef DISPLAY_GAP_EN
      ST_GAP: begin
        // Nothing pops while in GAP, so the waiting word is still there.
        if (err_pending_reg) begin
          state_next = ST_ERROR;
        end else if (dwell_reg == '0) begin
          pop        = 1'b1;
          dwell_next = DWELL_LOAD;
          state_next = ST_SHOW;
        end
      end
`endif
      ST_ERROR: begin
        if (!err_pending_reg) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Display word follows the registered state, one cycle behind it; a popped
  // word lands one cycle after the pop (after the FIFO read register).
  always_comb begin
    signal_to_display_next = signal_to_display_reg;
    if (state_reg == ST_ERROR) begin
      signal_to_display_next = ERR_WORD;
    end else if (pop_d_reg) begin
      signal_to_display_next = rd_data_reg;
    end else if (state_reg == ST_IDLE) begin
      signal_to_display_next = IDLE_WORD;
    end
`ifdef DISPLAY_GAP_EN
    else if (state_reg == ST_GAP) begin
      signal_to_display_next = IDLE_WORD;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg             <= ST_IDLE;
      dwell_reg             <= '0;
      fifo_count_reg        <= '0;
      wr_ptr_reg            <= '0;
      rd_ptr_reg            <= '0;
      err_pending_reg       <= 1'b0;
      overflow_reg          <= 1'b0;
      pop_d_reg             <= 1'b0;
      signal_to_display_reg <= IDLE_WORD;
    end else begin
      state_reg             <= state_next;
      dwell_reg             <= dwell_next;
      fifo_count_reg        <= fifo_count_next;
      if (push) wr_ptr_reg  <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
      err_pending_reg       <= err_pending_next;
      overflow_reg          <= overflow_next;
      pop_d_reg             <= pop;
      signal_to_display_reg <= signal_to_display_next;
    end
  end

  assign signal_to_display = signal_to_display_reg;
  assign fifo_count        = fifo_count_reg;
  assign overflow          = overflow_reg;
  assign rx_ready          = !full;
`ifdef DISPLAY_GAP_EN
  assign disp_busy = ((state_reg == ST_SHOW) && (dwell_reg != '0)) ||
                     (state_reg == ST_GAP);
`else
  assign disp_busy = (state_reg == ST_SHOW) && (dwell_reg != '0);
`endif

endmodule

// File: tb/tb_display_scheduler.sv
// -----------------------------------------------------------------------------
// tb_display_scheduler
//
// Directed bench for display_scheduler with DWELL_CYCLES=8, FIFO_DEPTH=4,
// GAP_CYCLES=4. Inputs change on the falling edge and outputs are sampled on
// the falling edge, so each "step" is one rising edge of the DUT. Expected
// values are hand-computed cycle positions relative to the drive edge.
// -----------------------------------------------------------------------------
module tb_display_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        rx_error = 1'b0;
  logic        err_clear = 1'b0;
  logic [15:0] signal_to_display;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        disp_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  display_scheduler #(
    .DWELL_CYCLES(8),
    .FIFO_DEPTH  (4),
    .ERR_WORD    (16'hEEEE),
    .IDLE_WORD   (16'hFFFF),
    .GAP_CYCLES  (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .rx_error         (rx_error),
    .err_clear        (err_clear),
    .signal_to_display(signal_to_display),
    .fifo_count       (fifo_count),
    .overflow         (overflow),
    .disp_busy        (disp_busy)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    step(3);
    n_checks++; if (signal_to_display !== 16'hFFFF) begin n_fail++; $display("FAIL reset_display: got %h want %h", signal_to_display, 16'hFFFF); end
    n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_checks++; if (disp_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", disp_busy); end
    reset = 1'b1;
    step(2);
    n_checks++; if (signal_to_display !== 16'hFFFF) begin n_fail++; $display("FAIL post_reset_display: got %h want %h", signal_to_display, 16'hFFFF); end
    $display("test_reset done");
  endtask

  task automatic test_single_word;
    rx_valid = 1'b1; rx_data = 16'h1234;
    step(1);
    rx_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count_push: got %0d want 1", fifo_count); end
    step(1);
    n_checks++; if (signal_to_display !== 16'hFFFF) begin n_fail++; $display("FAIL single_latency: got %h want %h", signal_to_display, 16'hFFFF); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL single_count_pop: got %0d want 0", fifo_count); end
    n_checks++; if (disp_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", disp_busy); end
    step(1);
    n_checks++; if (signal_to_display !== 16'h1234) begin n_fail++; $display("FAIL single_display: got %h want %h", signal_to_display, 16'h1234); end
    step(100);
    n_checks++; if (signal_to_display !== 16'h1234) begin n_fail++; $display("FAIL single_hold: got %h want %h", signal_to_display, 16'h1234); end
    n_checks++; if (disp_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", disp_busy); end
    $display("test_single_word done");
  endtask

  task automatic test_burst;
    rx_valid = 1'b1; rx_data = 16'hA1A1; step(1);
    rx_data = 16'hB2B2; step(1);
    rx_data = 16'hC3C3;
    n_checks++; if (signal_to_display !== 16'h1234) begin n_fail++; $display("FAIL burst_before: got %h want %h", signal_to_display, 16'h1234); end
    step(1);
    rx_valid = 1'b0;
    n_checks++; if (signal_to_display !== 16'hA1A1) begin n_fail++; $display("FAIL burst_a_first: got %h want %h", signal_to_display, 16'hA1A1); end
    n_checks++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL burst_count: got %0d want 2", fifo_count); end
    step(7);
    n_checks++; if (signal_to_display !== 16'hA1A1) begin n_fail++; $display("FAIL burst_a_last: got %h want %h", signal_to_display, 16'hA1A1); end
    step(1);
    n_checks++; if (signal_to_display !== 16'hB2B2) begin n_fail++; $display("FAIL burst_b_first: got %h want %h", signal_to_display, 16'hB2B2); end
    step(7);
    n_checks++; if (signal_to_display !== 16'hB2B2) begin n_fail++; $display("FAIL burst_b_last: got %h want %h", signal_to_display, 16'hB2B2); end
    step(1);
    n_checks++; if (signal_to_display !== 16'hC3C3) begin n_fail++; $display("FAIL burst_c_first: got %h want %h", signal_to_display, 16'hC3C3); end
    step(11);
    n_checks++; if (signal_to_display !== 16'hC3C3) begin n_fail++; $display("FAIL burst_c_hold: got %h want %h", signal_to_display, 16'hC3C3); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL burst_count_end: got %0d want 0", fifo_count); end
    $display("test_burst done");
  endtask

  task automatic test_overflow;
    logic [15:0] words [5];
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    words[3] = 16'h4444; words[4] = 16'h5555;
    rx_error = 1'b1; step(1);
    rx_error = 1'b0; step(1);
    n_checks++; if (signal_to_display !== 16'hC3C3) begin n_fail++; $display("FAIL ovf_err_latency: got %h want %h", signal_to_display, 16'hC3C3); end
    step(1);
    n_checks++; if (signal_to_display !== 16'hEEEE) begin n_fail++; $display("FAIL ovf_err_word: got %h want %h", signal_to_display, 16'hEEEE); end
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1; rx_data = words[i];
      step(1);
    end
    n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready_full: got %b want 0", rx_ready); end
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count_full: got %0d want 4", fifo_count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_not_yet: got %b want 0", overflow); end
    rx_data = words[4];
    step(1);
    rx_valid = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count_drop: got %0d want 4", fifo_count); end
    err_clear = 1'b1; step(1);
    err_clear = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: got %b want 0", overflow); end
    step(1);
    n_checks++; if (signal_to_display !== 16'hEEEE) begin n_fail++; $display("FAIL ovf_clear_latency: got %h want %h", signal_to_display, 16'hEEEE); end
    step(1);
    n_checks++; if (signal_to_display !== 16'hFFFF) begin n_fail++; $display("FAIL ovf_idle_gap: got %h want %h", signal_to_display, 16'hFFFF); end
    n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL ovf_count_pop: got %0d want 3", fifo_count); end
    step(1);
    n_checks++; if (signal_to_display !== 16'h1111) begin n_fail++; $display("FAIL ovf_w1_first: got %h want %h", signal_to_display, 16'h1111); end
    step(7);
    n_checks++; if (signal_to_display !== 16'h1111) begin n_fail++; $display("FAIL ovf_w1_last: got %h want %h", signal_to_display, 16'h1111); end
    step(1);
    n_checks++; if (signal_to_display !== 16'h2222) begin n_fail++; $display("FAIL ovf_w2: got %h want %h", signal_to_display, 16'h2222); end
    step(8);
    n_checks++; if (signal_to_display !== 16'h3333) begin n_fail++; $display("FAIL ovf_w3: got %h want %h", signal_to_display, 16'h3333); end
    step(8);
    n_checks++; if (signal_to_display !== 16'h4444) begin n_fail++; $display("FAIL ovf_w4: got %h want %h", signal_to_display, 16'h4444); end
    step(20);
    n_checks++; if (signal_to_display !== 16'h4444) begin n_fail++; $display("FAIL ovf_w4_hold: got %h want %h (5th word must be dropped)", signal_to_display, 16'h4444); end
    $display("test_overflow done");
  endtask

  task automatic test_error_preempt;
    rx_valid = 1'b1; rx_data = 16'h1234; step(1);
    rx_valid = 1'b0; step(2);
    n_checks++; if (signal_to_display !== 16'h1234) begin n_fail++; $display("FAIL pre_show: got %h want %h", signal_to_display, 16'h1234); end
    step(2);
    n_checks++; if (disp_busy !== 1'b1) begin n_fail++; $display("FAIL pre_busy: got %b want 1", disp_busy); end
    rx_error = 1'b1; step(1);
    rx_error = 1'b0; step(1);
    n_checks++; if (signal_to_display !== 16'h1234) begin n_fail++; $display("FAIL pre_latency: got %h want %h", signal_to_display, 16'h1234); end
    n_checks++; if (disp_busy !== 1'b0) begin n_fail++; $display("FAIL pre_busy_err: got %b want 0", disp_busy); end
    step(1);
    n_checks++; if (signal_to_display !== 16'hEEEE) begin n_fail++; $display("FAIL pre_err_word: got %h want %h", signal_to_display, 16'hEEEE); end
    rx_error = 1'b1; err_clear = 1'b1; step(1);
    rx_error = 1'b0; err_clear = 1'b0; step(3);
    n_checks++; if (signal_to_display !== 16'hEEEE) begin n_fail++; $display("FAIL pre_both_keep: got %h want %h", signal_to_display, 16'hEEEE); end
    err_clear = 1'b1; step(1);
    err_clear = 1'b0; step(1);
    n_checks++; if (signal_to_display !== 16'hEEEE) begin n_fail++; $display("FAIL pre_clear_latency: got %h want %h", signal_to_display, 16'hEEEE); end
    step(1);
    n_checks++; if (signal_to_display !== 16'hFFFF) begin n_fail++; $display("FAIL pre_cleared: got %h want %h", signal_to_display, 16'hFFFF); end
    step(5);
    n_checks++; if (signal_to_display !== 16'hFFFF) begin n_fail++; $display("FAIL pre_idle_hold: got %h want %h", signal_to_display, 16'hFFFF); end
    $display("test_error_preempt done");
  endtask

  task automatic test_reset_mid;
    rx_valid = 1'b1; rx_data = 16'h0A0A; step(1);
    rx_data = 16'h0B0B; step(1);
    rx_data = 16'h0C0C; step(1);
    rx_valid = 1'b0;
    n_checks++; if (signal_to_display !== 16'h0A0A) begin n_fail++; $display("FAIL mid_show: got %h want %h", signal_to_display, 16'h0A0A); end
    n_checks++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL mid_count: got %0d want 2", fifo_count); end
    step(1);
    #1 reset = 1'b0;
    #1;
    n_checks++; if (signal_to_display !== 16'hFFFF) begin n_fail++; $display("FAIL mid_async_display: got %h want %h", signal_to_display, 16'hFFFF); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL mid_async_count: got %0d want 0", fifo_count); end
    step(2);
    reset = 1'b1;
    step(30);
    n_checks++; if (signal_to_display !== 16'hFFFF) begin n_fail++; $display("FAIL mid_no_stale: got %h want %h", signal_to_display, 16'hFFFF); end
    n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", rx_ready); end
    $display("test_reset_mid done");
  endtask

`ifdef DISPLAY_GAP_EN
  task automatic test_gap;
    rx_valid = 1'b1; rx_data = 16'h6161; step(1);
    rx_data = 16'h7272; step(1);
    rx_valid = 1'b0; step(1);
    n_checks++; if (signal_to_display !== 16'h6161) begin n_fail++; $display("FAIL gap_w1_first: got %h want %h", signal_to_display, 16'h6161); end
    step(7);
    n_checks++; if (signal_to_display !== 16'h6161) begin n_fail++; $display("FAIL gap_w1_last: got %h want %h", signal_to_display, 16'h6161); end
    step(1);
    n_checks++; if (signal_to_display !== 16'hFFFF) begin n_fail++; $display("FAIL gap_blank_first: got %h want %h", signal_to_display, 16'hFFFF); end
    n_checks++; if (disp_busy !== 1'b1) begin n_fail++; $display("FAIL gap_busy: got %b want 1", disp_busy); end
    step(3);
    n_checks++; if (signal_to_display !== 16'hFFFF) begin n_fail++; $display("FAIL gap_blank_last: got %h want %h", signal_to_display, 16'hFFFF); end
    step(1);
    n_checks++; if (signal_to_display !== 16'h7272) begin n_fail++; $display("FAIL gap_w2: got %h want %h", signal_to_display, 16'h7272); end
    $display("test_gap done");
  endtask
`endif

  initial begin
    test_reset();
`ifdef DISPLAY_GAP_EN
    test_gap();
`else
    test_single_word();
    test_burst();
    test_overflow();
    test_error_preempt();
    test_reset_mid();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
